// File: rtl/floo_id_dst_tracker.sv
// Per-txnID outstanding-transaction tracker: a txnID may only issue to the destination its
// in-flight transactions target. Define FLOO_ID_DST_TRACKER_PERF_EN to build the stall monitor.
module floo_id_dst_tracker #(
  parameter int unsigned NumIds       = 4,
  parameter int unsigned MaxTxnsPerId = 32,
  parameter int unsigned DstWidth     = 8,
  localparam int unsigned IdWidth     = (NumIds > 1) ? $clog2(NumIds) : 1,
  localparam int unsigned CntWidth    = $clog2(MaxTxnsPerId + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [IdWidth-1:0]  req_id_i,
  input  logic [DstWidth-1:0] req_dst_i,
  output logic                req_valid_o,
  input  logic                req_ready_i,
  input  logic                rsp_valid_i,
  input  logic                rsp_ready_i,
  input  logic [IdWidth-1:0]  rsp_id_i,
  output logic                idle_o,
  output logic                err_o,
  output logic [31:0]         stall_cycles_o
);

  localparam logic [CntWidth-1:0] CntMax = CntWidth'(MaxTxnsPerId);

  logic [CntWidth-1:0] cntQ [NumIds];
  logic [CntWidth-1:0] cntD [NumIds];
  logic [DstWidth-1:0] dstQ [NumIds];
  logic [DstWidth-1:0] dstD [NumIds];
  logic                errQ, errD;
  logic [CntWidth-1:0] reqCnt;
  logic [DstWidth-1:0] reqDst;
  logic                reqIdOk, rspIdOk, stall, push, pop, idle;

  // Out-of-range IDs never match a slot, so they read as an empty entry.
  always_comb begin
    reqCnt = '0;
    reqDst = '0;
    for (int unsigned i = 0; i < NumIds; i++) begin
      if (req_id_i == IdWidth'(i)) begin
        reqCnt = cntQ[i];
        reqDst = dstQ[i];
      end
    end
  end

  assign reqIdOk = 32'(req_id_i) < NumIds;
  assign rspIdOk = 32'(rsp_id_i) < NumIds;

  // Registered state only: a same-cycle response never releases a stall.
  assign stall = ~reqIdOk | ((reqCnt != '0) & (reqDst != req_dst_i)) | (reqCnt == CntMax);

  assign req_valid_o = req_valid_i & ~stall;
  assign req_ready_o = req_ready_i & ~stall;
  assign push        = req_valid_o & req_ready_i;
  assign pop         = rsp_valid_i & rsp_ready_i;

  always_comb begin
    errD = errQ;
    for (int unsigned i = 0; i < NumIds; i++) begin
      cntD[i] = cntQ[i];
      dstD[i] = dstQ[i];
      if (push && (req_id_i == IdWidth'(i))) begin
        dstD[i] = req_dst_i;
      end
      if (push && (req_id_i == IdWidth'(i)) && !(pop && (rsp_id_i == IdWidth'(i)))) begin
        cntD[i] = cntQ[i] + CntWidth'(1);
      end else if (pop && (rsp_id_i == IdWidth'(i)) && !(push && (req_id_i == IdWidth'(i)))) begin
        if (cntQ[i] != '0) begin
          cntD[i] = cntQ[i] - CntWidth'(1);
        end else begin
          errD = 1'b1;
        end
      end
    end
    if (pop && !rspIdOk) begin
      errD = 1'b1;
    end
  end

  always_comb begin
    idle = 1'b1;
    for (int unsigned i = 0; i < NumIds; i++) begin
      if (cntQ[i] != '0) begin
        idle = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cntQ <= '{default: '0};
      dstQ <= '{default: '0};
      errQ <= 1'b0;
    end else begin
      cntQ <= cntD;
      dstQ <= dstD;
      errQ <= errD;
    end
  end

  assign idle_o = idle;
  assign err_o  = errQ;

`ifdef FLOO_ID_DST_TRACKER_PERF_EN
  logic [31:0] stallCntQ;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stallCntQ <= '0;
    end else if (req_valid_i && stall && (stallCntQ != '1)) begin
      stallCntQ <= stallCntQ + 32'd1;
    end
  end

  assign stall_cycles_o = stallCntQ;
`else
  assign stall_cycles_o = '0;
`endif

endmodule
